// File: rtl/traffic_sink.sv
// traffic_sink: NoC ejection endpoint. Reassembles packets per VC, checks framing/destination,
// returns credits after a programmable delay, counts flits/packets. TRAFFIC_SINK_LATENCY_EN adds latency stats.
module traffic_sink #(
   parameter int MAXVC        = 4,
   parameter int VC_BITS      = 2,
   parameter int DST_BITS     = 4,
   parameter int MAX_CR_DELAY = 8,
   parameter int CNT_W        = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          sink_op,
   input  logic [DST_BITS-1:0] cfg_id,
   input  logic [VC_BITS:0]    cfg_num_vcs,
   input  logic [3:0]          cfg_cr_delay,
   input  logic [CNT_W-1:0]    cfg_exp_pkts,
   input  logic                in_full,
   input  logic [VC_BITS-1:0]  in_vc,
   input  logic                in_head,
   input  logic                in_tail,
   input  logic [DST_BITS-1:0] in_dst,
`ifdef TRAFFIC_SINK_LATENCY_EN
   input  logic [15:0]         in_ts,
   output logic [31:0]         lat_sum,
   output logic [15:0]         lat_max,
`endif
   output logic                cr_full,
   output logic [VC_BITS-1:0]  cr_vc,
   output logic [CNT_W-1:0]    flit_cnt,
   output logic [CNT_W-1:0]    pkt_cnt,
   output logic [3:0]          err,
   output logic                done
);
   localparam int         DL_W  = (MAX_CR_DELAY > 1) ? $clog2(MAX_CR_DELAY) : 1;
   localparam logic [3:0] MAX_D = 4'(MAX_CR_DELAY);

   typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} vc_st_e;

   vc_st_e                                  vc_q [MAXVC];
   vc_st_e                                  vc_d [MAXVC];
   logic [MAX_CR_DELAY-1:0]                 dl_vld_q, dl_vld_d;
   logic [MAX_CR_DELAY-1:0][VC_BITS-1:0]    dl_vc_q, dl_vc_d;
   logic [DST_BITS-1:0]                     cfg_id_q, cfg_id_d;
   logic [VC_BITS:0]                        num_vcs_q, num_vcs_d;
   logic [3:0]                              cr_delay_q, cr_delay_d;
   logic [CNT_W-1:0]                        exp_pkts_q, exp_pkts_d;
   logic [CNT_W-1:0]                        flit_cnt_q, flit_cnt_d, pkt_cnt_q, pkt_cnt_d;
   logic [3:0]                              err_q, err_d;
   logic                                    init_seen_q, init_seen_d, done_q, done_d;
   logic                                    op_init, vc_ok, acc, pkt_done, all_idle;
   logic [DL_W-1:0]                         ins_idx;

   always_comb begin
      vc_d        = vc_q;
      cfg_id_d    = cfg_id_q;
      num_vcs_d   = num_vcs_q;
      cr_delay_d  = cr_delay_q;
      exp_pkts_d  = exp_pkts_q;
      flit_cnt_d  = flit_cnt_q;
      pkt_cnt_d   = pkt_cnt_q;
      err_d       = err_q;
      init_seen_d = init_seen_q;
      pkt_done    = 1'b0;
      op_init     = (sink_op == 2'd1);
      vc_ok       = ({1'b0, in_vc} < num_vcs_q);
      acc         = in_full && vc_ok;
      ins_idx     = DL_W'(cr_delay_q - 4'd1);
      for (int i = 0; i < MAX_CR_DELAY-1; i++) begin
         dl_vld_d[i] = dl_vld_q[i+1];
         dl_vc_d[i]  = dl_vc_q[i+1];
      end
      dl_vld_d[MAX_CR_DELAY-1] = 1'b0;
      dl_vc_d[MAX_CR_DELAY-1]  = '0;
      all_idle = 1'b1;
      for (int i = 0; i < MAXVC; i++)
         if (vc_q[i] == OPEN) all_idle = 1'b0;

      if (op_init) begin
         cfg_id_d    = cfg_id;
         num_vcs_d   = cfg_num_vcs;
         cr_delay_d  = (cfg_cr_delay == 4'd0) ? 4'd1 :
                       (cfg_cr_delay > MAX_D) ? MAX_D : cfg_cr_delay;
         exp_pkts_d  = cfg_exp_pkts;
         init_seen_d = 1'b1;
         flit_cnt_d  = '0;
         pkt_cnt_d   = '0;
         err_d       = '0;
         dl_vld_d    = '0;
         dl_vc_d     = '0;
         for (int i = 0; i < MAXVC; i++) vc_d[i] = IDLE;
      end else begin
         if (sink_op == 2'd2) err_d = '0;
         if (in_full && !vc_ok) err_d[3] = 1'b1;
         if (acc) begin
            if (flit_cnt_q != '1) flit_cnt_d = flit_cnt_q + 1'b1;
            if (in_dst != cfg_id_q) err_d[2] = 1'b1;
            // Inserting at stage delay-1 makes the credit reach stage 0 exactly delay cycles later.
            dl_vld_d[ins_idx] = 1'b1;
            dl_vc_d[ins_idx]  = in_vc;
            if (in_head) begin
               if (vc_q[in_vc] == OPEN) err_d[1] = 1'b1;
               vc_d[in_vc] = in_tail ? IDLE : OPEN;
               pkt_done    = in_tail;
            end else if (vc_q[in_vc] == IDLE) begin
               err_d[0] = 1'b1;
            end else if (in_tail) begin
               vc_d[in_vc] = IDLE;
               pkt_done    = 1'b1;
            end
         end
         if (pkt_done && pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + 1'b1;
      end
      // Stage 0 is the credit being handed to the router this cycle, so it no longer counts as pending.
      done_d = !op_init && init_seen_q && (pkt_cnt_q >= exp_pkts_q) && all_idle &&
               ((dl_vld_q >> 1) == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAXVC; i++) vc_q[i] <= IDLE;
         dl_vld_q    <= '0;
         dl_vc_q     <= '0;
         cfg_id_q    <= '0;
         num_vcs_q   <= (VC_BITS+1)'(1);
         cr_delay_q  <= 4'd1;
         exp_pkts_q  <= '0;
         flit_cnt_q  <= '0;
         pkt_cnt_q   <= '0;
         err_q       <= '0;
         init_seen_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         vc_q        <= vc_d;
         dl_vld_q    <= dl_vld_d;
         dl_vc_q     <= dl_vc_d;
         cfg_id_q    <= cfg_id_d;
         num_vcs_q   <= num_vcs_d;
         cr_delay_q  <= cr_delay_d;
         exp_pkts_q  <= exp_pkts_d;
         flit_cnt_q  <= flit_cnt_d;
         pkt_cnt_q   <= pkt_cnt_d;
         err_q       <= err_d;
         init_seen_q <= init_seen_d;
         done_q      <= done_d;
      end
   end

   assign cr_full  = dl_vld_q[0];
   assign cr_vc    = dl_vc_q[0];
   assign flit_cnt = flit_cnt_q;
   assign pkt_cnt  = pkt_cnt_q;
   assign err      = err_q;
   assign done     = done_q;

`ifdef TRAFFIC_SINK_LATENCY_EN
   logic [15:0] cyc_q, cyc_d, lat_max_q, lat_max_d, lat;
   logic [31:0] lat_sum_q, lat_sum_d;
   logic [32:0] sum_w;

   always_comb begin
      lat       = cyc_q - in_ts;
      sum_w     = {1'b0, lat_sum_q} + {17'b0, lat};
      cyc_d     = cyc_q + 16'd1;
      lat_sum_d = lat_sum_q;
      lat_max_d = lat_max_q;
      if (op_init) begin
         cyc_d     = '0;
         lat_sum_d = '0;
         lat_max_d = '0;
      end else if (pkt_done) begin
         lat_sum_d = sum_w[32] ? '1 : sum_w[31:0];
         if (lat > lat_max_q) lat_max_d = lat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_q     <= '0;
         lat_sum_q <= '0;
         lat_max_q <= '0;
      end else begin
         cyc_q     <= cyc_d;
         lat_sum_q <= lat_sum_d;
         lat_max_q <= lat_max_d;
      end
   end

   assign lat_sum = lat_sum_q;
   assign lat_max = lat_max_q;
`endif
endmodule

// File: tb/tb_traffic_sink.sv
// Directed bench for traffic_sink: credit scoreboard with arrival-cycle checks plus counter/err/done checks.
`timescale 1ns/1ps
module tb_traffic_sink;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [1:0]  sink_op = 2'd0;
   logic [3:0]  cfg_id = 4'd0;
   logic [2:0]  cfg_num_vcs = 3'd1;
   logic [3:0]  cfg_cr_delay = 4'd1;
   logic [15:0] cfg_exp_pkts = 16'd0;
   logic        in_full = 1'b0;
   logic [1:0]  in_vc = 2'd0;
   logic        in_head = 1'b0;
   logic        in_tail = 1'b0;
   logic [3:0]  in_dst = 4'd0;
   logic [15:0] in_ts = 16'd0;
   logic        cr_full;
   logic [1:0]  cr_vc;
   logic [15:0] flit_cnt, pkt_cnt;
   logic [3:0]  err;
   logic        done;
`ifdef TRAFFIC_SINK_LATENCY_EN
   logic [31:0] lat_sum;
   logic [15:0] lat_max;
`endif

   traffic_sink dut (
      .clk(clk), .rst_n(rst_n), .sink_op(sink_op), .cfg_id(cfg_id),
      .cfg_num_vcs(cfg_num_vcs), .cfg_cr_delay(cfg_cr_delay), .cfg_exp_pkts(cfg_exp_pkts),
      .in_full(in_full), .in_vc(in_vc), .in_head(in_head), .in_tail(in_tail), .in_dst(in_dst),
`ifdef TRAFFIC_SINK_LATENCY_EN
      .in_ts(in_ts), .lat_sum(lat_sum), .lat_max(lat_max),
`endif
      .cr_full(cr_full), .cr_vc(cr_vc), .flit_cnt(flit_cnt), .pkt_cnt(pkt_cnt),
      .err(err), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int due; logic [1:0] vc; } cr_t;
   cr_t sb[$];
   int  n_chk = 0, n_fail = 0, dly = 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] vc, input logic h, input logic t, input logic [3:0] dst,
                       input bit cr, input logic [15:0] ts);
      cr_t e;
      in_full = 1'b1; in_vc = vc; in_head = h; in_tail = t; in_dst = dst; in_ts = ts;
      if (cr) begin
         e.due = cyc + dly;
         e.vc  = vc;
         sb.push_back(e);
      end
      tick();
      in_full = 1'b0; in_head = 1'b0; in_tail = 1'b0;
   endtask

   task automatic do_init(input logic [3:0] id, input logic [2:0] nv, input logic [3:0] d,
                          input logic [15:0] exp, input bit junk);
      cfg_id = id; cfg_num_vcs = nv; cfg_cr_delay = d; cfg_exp_pkts = exp;
      sink_op = 2'd1;
      // An Init-cycle flit must be ignored entirely.
      if (junk) begin
         in_full = 1'b1; in_vc = 2'd0; in_head = 1'b1; in_tail = 1'b0; in_dst = id;
      end
      tick();
      sink_op = 2'd0; in_full = 1'b0; in_head = 1'b0;
      dly = (d == 4'd0) ? 1 : (d > 4'd8) ? 8 : int'(d);
   endtask

   task automatic drain(input int n);
      repeat (n) tick();
      chk("sb_empty", 32'(sb.size()), 32'd0);
   endtask

   always @(negedge clk) begin : mon
      cr_t e;
      if (rst_n && cr_full) begin
         if (sb.size() == 0) chk("cr_spurious", 32'(cr_full), 32'd0);
         else begin
            e = sb.pop_front();
            chk("cr_vc", 32'(cr_vc), 32'(e.vc));
            chk("cr_cycle", 32'(cyc), 32'(e.due));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst_n = 1'b0;
      tick(); tick();
      chk("rst_cr_full", 32'(cr_full), 32'd0);
      chk("rst_cr_vc", 32'(cr_vc), 32'd0);
      chk("rst_flit", 32'(flit_cnt), 32'd0);
      chk("rst_pkt", 32'(pkt_cnt), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      repeat (3) tick();
      chk("no_init_done", 32'(done), 32'd0);

      // 3-flit packet on vc1, delay 2
      do_init(4'd3, 3'd2, 4'd2, 16'd1, 1'b1);
      send(2'd1, 1'b1, 1'b0, 4'd3, 1'b1, 16'd0);
      send(2'd1, 1'b0, 1'b0, 4'd3, 1'b1, 16'd0);
      send(2'd1, 1'b0, 1'b1, 4'd3, 1'b1, 16'd0);
      tick();
      chk("done_early", 32'(done), 32'd0);
      tick();
      chk("done_t3", 32'(done), 32'd1);
      drain(6);
      chk("p1_flit", 32'(flit_cnt), 32'd3);
      chk("p1_pkt", 32'(pkt_cnt), 32'd1);
      chk("p1_err", 32'(err), 32'd0);
      chk("p1_done", 32'(done), 32'd1);

      // interleaved VCs
      do_init(4'd3, 3'd2, 4'd2, 16'd2, 1'b0);
      chk("init_clr_done", 32'(done), 32'd0);
      send(2'd0, 1'b1, 1'b0, 4'd3, 1'b1, 16'd0);
      send(2'd1, 1'b1, 1'b1, 4'd3, 1'b1, 16'd0);
      send(2'd0, 1'b0, 1'b1, 4'd3, 1'b1, 16'd0);
      drain(6);
      chk("p2_pkt", 32'(pkt_cnt), 32'd2);
      chk("p2_flit", 32'(flit_cnt), 32'd3);
      chk("p2_err", 32'(err), 32'd0);
      chk("p2_done", 32'(done), 32'd1);

      // framing errors
      do_init(4'd3, 3'd2, 4'd1, 16'd0, 1'b0);
      send(2'd0, 1'b0, 1'b0, 4'd3, 1'b1, 16'd0);
      chk("err_body_idle", 32'(err), 32'd1);
      send(2'd0, 1'b1, 1'b0, 4'd3, 1'b1, 16'd0);
      send(2'd0, 1'b1, 1'b0, 4'd3, 1'b1, 16'd0);
      chk("err_head_open", 32'(err), 32'd3);
      chk("p3_pkt", 32'(pkt_cnt), 32'd0);
      chk("done_open_vc", 32'(done), 32'd0);
      sink_op = 2'd2; tick(); sink_op = 2'd0;
      chk("clr_err", 32'(err), 32'd0);
      send(2'd0, 1'b0, 1'b1, 4'd3, 1'b1, 16'd0);
      chk("p3_pkt_tail", 32'(pkt_cnt), 32'd1);
      chk("p3_flit", 32'(flit_cnt), 32'd4);

      // bad VC dropped, wrong dst accepted
      send(2'd3, 1'b1, 1'b1, 4'd3, 1'b0, 16'd0);
      chk("err_vc", 32'(err), 32'd8);
      chk("vc_drop_flit", 32'(flit_cnt), 32'd4);
      send(2'd0, 1'b1, 1'b1, 4'd5, 1'b1, 16'd0);
      chk("err_dst", 32'(err), 32'hC);
      chk("dst_pkt", 32'(pkt_cnt), 32'd2);
      chk("dst_flit", 32'(flit_cnt), 32'd5);
      drain(4);

      // delay coercion and clamping
      do_init(4'd3, 3'd2, 4'd0, 16'd0, 1'b0);
      send(2'd1, 1'b1, 1'b1, 4'd3, 1'b1, 16'd0);
      chk("d0_cr_now", 32'(cr_full), 32'd1);
      drain(4);
      do_init(4'd3, 3'd2, 4'd15, 16'd0, 1'b0);
      send(2'd0, 1'b1, 1'b1, 4'd3, 1'b1, 16'd0);
      repeat (6) tick();
      chk("d15_cr_early", 32'(cr_full), 32'd0);
      tick();
      chk("d15_cr_at8", 32'(cr_full), 32'd1);
      drain(4);

      // async reset mid-packet with a credit on the output
      do_init(4'd3, 3'd2, 4'd1, 16'd5, 1'b0);
      send(2'd0, 1'b1, 1'b0, 4'd3, 1'b1, 16'd0);
      chk("pre_rst_cr", 32'(cr_full), 32'd1);
      chk("pre_rst_flit", 32'(flit_cnt), 32'd1);
      #2 rst_n = 1'b0;
      sb.delete();
      #1;
      chk("arst_cr_full", 32'(cr_full), 32'd0);
      chk("arst_flit", 32'(flit_cnt), 32'd0);
      chk("arst_pkt", 32'(pkt_cnt), 32'd0);
      chk("arst_err", 32'(err), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("post_rst_done", 32'(done), 32'd0);

`ifdef TRAFFIC_SINK_LATENCY_EN
      begin
         int base;
         do_init(4'd3, 3'd2, 4'd1, 16'd0, 1'b0);
         base = cyc;
         while (cyc - base < 40) tick();
         send(2'd0, 1'b1, 1'b1, 4'd3, 1'b1, 16'd30);
         while (cyc - base < 50) tick();
         send(2'd1, 1'b1, 1'b1, 4'd3, 1'b1, 16'd45);
         chk("lat_sum", lat_sum, 32'd15);
         chk("lat_max", 32'(lat_max), 32'd10);
         drain(3);
         do_init(4'd3, 3'd2, 4'd1, 16'd0, 1'b0);
         chk("lat_clr", lat_sum, 32'd0);
         base = cyc;
         while (cyc - base < 5) tick();
         send(2'd0, 1'b1, 1'b1, 4'd3, 1'b1, 16'd65530);
         chk("lat_wrap_sum", lat_sum, 32'd11);
         chk("lat_wrap_max", 32'(lat_max), 32'd11);
         drain(3);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/traffic_sink.md
Name: traffic_sink

Overview:
- Ejection-side endpoint of the NoC: the receiving counterpart of the per-router traffic injector.
- Accepts flits from a router's ejection output staging port and reassembles packets per VC.
- Checks head/tail framing and destination, and returns credits to the router after the configured credit delay.
- Counts received flits and packets; asserts done once the programmed packet count has fully arrived and all credits have drained.

Parameters:
- MAXVC, 4, number of VC state slots supported.
- VC_BITS, 2, width of the VC index.
- DST_BITS, 4, router-id width (matches the flit destination field).
- MAX_CR_DELAY, 8, depth of the credit delay line (maximum credit delay).
- CNT_W, 16, width of the flit and packet counters.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sink_op  in  2  0=NOP, 1=Init, 2=ClrErr, 3=reserved (treated as NOP).
- cfg_id  in  DST_BITS  this sink's router id; latched on Init.
- cfg_num_vcs  in  VC_BITS+1  active VC count, 1..MAXVC; latched on Init.
- cfg_cr_delay  in  4  credit delay in cycles; latched on Init.
- cfg_exp_pkts  in  CNT_W  expected packet count; latched on Init.
- in_full  in  1  flit valid (staging BufferFull).
- in_vc  in  VC_BITS  flit VC.
- in_head  in  1  head-flit marker.
- in_tail  in  1  tail-flit marker.
- in_dst  in  DST_BITS  flit destination.
- cr_full  out  1  credit valid toward the router's credit staging.
- cr_vc  out  VC_BITS  VC of the returned credit.
- flit_cnt  out  CNT_W  accepted flits.
- pkt_cnt  out  CNT_W  completed packets (tails accepted).
- err  out  4  sticky flags: [0] body/tail with no open packet, [1] head on an open packet, [2] dst≠cfg_id, [3] vc≥num_vcs.
- done  out  1  all expected packets received and sink quiescent.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: cr_full=0, cr_vc=0, flit_cnt=0, pkt_cnt=0, err=0, done=0.
  - All VC slots IDLE, credit delay line empty.
  - Config registers: cfg_id=0, num_vcs=1, cr_delay=1, exp_pkts=0.
- Init (sink_op=1):
  - Latches all cfg_* inputs. cr_delay=0 is coerced to 1; values >MAX_CR_DELAY are clamped to MAX_CR_DELAY.
  - Clears counters, err, VC states and the delay line. done=0 next cycle.
  - A flit presented in the Init cycle is ignored: no count, no credit.
- ClrErr (sink_op=2): clears err only. Flit handling proceeds normally that cycle.
- Flit acceptance (in_full=1, not an Init cycle):
  - vc≥num_vcs: set err[3]; drop the flit; no credit; no count.
  - Otherwise the flit is accepted: flit_cnt+1, and a credit for in_vc is scheduled.
  - in_dst≠cfg_id: set err[2]. The flit is still accepted and framed.
- Per-VC framing FSM (states IDLE, OPEN):
  - IDLE, head&tail: packet complete, pkt_cnt+1, stay IDLE.
  - IDLE, head&!tail: go to OPEN.
  - IDLE, !head: set err[0]. If tail, stay IDLE with no pkt_cnt increment.
  - OPEN, !head&!tail: stay OPEN.
  - OPEN, !head&tail: pkt_cnt+1, go to IDLE.
  - OPEN, head: set err[1]. The old packet is abandoned without counting. The head then applies as in IDLE (head&tail completes immediately, otherwise stay OPEN).
- Credit return:
  - The delay line is a MAX_CR_DELAY-stage shift register of {valid, vc}.
  - The credit for a flit accepted in cycle N appears on cr_full/cr_vc at cycle N+cr_delay, exactly one cycle wide.
  - Throughput is one flit per cycle, so at most one credit enters and one leaves per cycle; the line never overflows.
- Counters saturate at all-ones (no wrap).
- done=1 when all of the following hold: pkt_cnt≥exp_pkts, all VCs IDLE, delay line empty, and at least one Init seen since reset. done is registered (1-cycle lag). It drops if a later flit opens a VC.
- Reset asserted mid-packet: state and credits in flight are discarded immediately (async). The router side is reinitialised by the same flow.

Optional Feature:
- Macro: TRAFFIC_SINK_LATENCY_EN.
- Defined:
  - Adds port in_ts (in, 16, injection timestamp carried with the flit) and outputs lat_sum (out, 32) and lat_max (out, 16).
  - An internal 16-bit cycle counter runs from Init; it is zeroed on Init and on reset.
  - On each counted tail, lat=(cycle−in_ts) mod 2^16. lat_sum+=lat, saturating at 2^32−1; lat_max=max(lat_max, lat).
  - Both are cleared on Init and on reset.
- Undefined: no extra ports, no cycle counter; behaviour is otherwise identical.

Test Plan:
- Reset → Init (id=3, num_vcs=2, cr_delay=2, exp=1); inject a 3-flit packet on vc1, dst=3, in cycles 10/11/12 → cr_full on vc1 at cycles 12/13/14; flit_cnt=3, pkt_cnt=1, err=0, done=1 by cycle 15.
- Interleave: vc0 head, vc1 head&tail, vc0 tail on consecutive cycles (exp=2) → pkt_cnt=2, err=0, credits vc0, vc1, vc0 in order.
- Body flit on idle vc0 → err=0001, credit still returned. Then head, head on vc0 → err=0011, pkt_cnt unchanged. ClrErr → err=0000.
- Flit on vc=3 with num_vcs=2 → err[3]=1, no credit, flit_cnt unchanged. Flit with dst=5 ≠ id=3 → err[2]=1, credit returned.
- Init with cr_delay=0, then with cr_delay=15 (MAX_CR_DELAY=8) → credit latency 1 cycle, then 8 cycles respectively. Drop rst_n mid-packet with credits pending → cr_full=0 immediately, all counters 0.
- With TRAFFIC_SINK_LATENCY_EN: tails arriving at cycle 40 with ts=30 and at cycle 50 with ts=45 → lat_sum=15, lat_max=10. Tail at cycle 5 with ts=65530 → lat=11 (wrap).
